// File: rtl/imem_arbiter.sv
// Arbiter for one instruction memory shared by a boot loader and the core fetch port.
// Optional RUN-state loader starvation guard is enabled by defining IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_valid,
    output logic              core_stall,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_done,
    output logic              ldr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              boot_busy,
    output logic [CNT_W-1:0]  load_count
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LOAD_MAX = CNT_W'(64);

    state_t            state;
    logic              core_grant;
    logic              ldr_grant;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  load_cnt;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    logic [1:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = ldr_req && (starve_cnt == 2'd3);

    // Counts RUN cycles in which the loader waits; cleared whenever it is served or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 2'd0;
        end else if (state != RUN || !ldr_req || ldr_grant) begin
            starve_cnt <= 2'd0;
        end else if (starve_cnt != 2'd3) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end
`else
    logic starve_hit;
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        core_grant = 1'b0;
        ldr_grant  = 1'b0;
        if (state == BOOT) begin
            ldr_grant = ldr_req;
        end else if (starve_hit) begin
            ldr_grant = 1'b1;
        end else if (core_req) begin
            core_grant = 1'b1;
        end else begin
            ldr_grant = ldr_req;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (ldr_grant) begin
            mem_addr  = ldr_addr;
            mem_we    = 1'b1;
            mem_wdata = ldr_wdata;
        end else if (core_grant) begin
            mem_addr = core_addr;
        end
    end

    assign ldr_ack    = ldr_grant;
    assign core_stall = core_req && !core_grant;
    assign boot_busy  = (state == BOOT);
    assign core_rdata = rdata_p1;
    assign core_valid = vld_p1;
    assign load_count = load_cnt;

    // Stage p1: fetch data captured one cycle after the core grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            load_cnt <= '0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= core_grant;
            if (core_grant) begin
                rdata_p1 <= mem_rdata;
            end
            if (state == BOOT) begin
                if (ldr_grant && load_cnt != LOAD_MAX) begin
                    load_cnt <= load_cnt + CNT_W'(1);
                end
                if (ldr_done) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table plus read-data scoreboard.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic [5:0]  core_addr;
    logic [31:0] core_rdata;
    logic        core_valid;
    logic        core_stall;
    logic        ldr_req;
    logic [5:0]  ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_done;
    logic        ldr_ack;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        boot_busy;
    logic [6:0]  load_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] sb_q    [$];

    typedef struct {
        logic        core_req;
        logic [5:0]  core_addr;
        logic        ldr_req;
        logic [5:0]  ldr_addr;
        logic [31:0] ldr_wdata;
        logic        ldr_done;
        logic        exp_ack;
        logic        exp_stall;
        logic        exp_busy;
        logic [6:0]  exp_cnt;
    } vec_t;

    vec_t tbl[11];

    imem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_rdata (core_rdata),
        .core_valid (core_valid),
        .core_stall (core_stall),
        .ldr_req    (ldr_req),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_done   (ldr_done),
        .ldr_ack    (ldr_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .boot_busy  (boot_busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic vec_t mk(input logic cr, input logic [5:0] ca, input logic lr,
                                input logic [5:0] la, input logic [31:0] lw, input logic ld,
                                input logic ea, input logic es, input logic eb,
                                input logic [6:0] ec);
        vec_t v;
        v.core_req = cr; v.core_addr = ca; v.ldr_req = lr; v.ldr_addr = la;
        v.ldr_wdata = lw; v.ldr_done = ld; v.exp_ack = ea; v.exp_stall = es;
        v.exp_busy = eb; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_addr = '0; ldr_req = 1'b0;
        ldr_addr = '0; ldr_wdata = '0; ldr_done = 1'b0;
    endtask

    // Drives one cycle, checks outputs mid-cycle, and retires the scoreboard entry due now.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_d;
        logic        exp_core;
        core_req = v.core_req; core_addr = v.core_addr; ldr_req = v.ldr_req;
        ldr_addr = v.ldr_addr; ldr_wdata = v.ldr_wdata; ldr_done = v.ldr_done;
        @(negedge clk);
        check({tag, "_core_valid"}, 32'(core_valid), 32'(sb_q.size() != 0));
        if (core_valid && sb_q.size() != 0) begin
            exp_d = sb_q.pop_front();
            check({tag, "_core_rdata"}, core_rdata, exp_d);
        end
        exp_core = v.core_req && !v.exp_stall;
        check({tag, "_ldr_ack"}, 32'(ldr_ack), 32'(v.exp_ack));
        check({tag, "_core_stall"}, 32'(core_stall), 32'(v.exp_stall));
        check({tag, "_boot_busy"}, 32'(boot_busy), 32'(v.exp_busy));
        check({tag, "_load_count"}, 32'(load_count), 32'(v.exp_cnt));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(v.exp_ack));
        if (v.exp_ack) begin
            check({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.ldr_addr));
            check({tag, "_mem_wdata"}, mem_wdata, v.ldr_wdata);
            ref_mem[v.ldr_addr] = v.ldr_wdata;
        end else if (exp_core) begin
            check({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.core_addr));
            sb_q.push_back(ref_mem[v.core_addr]);
        end else begin
            check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
            check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit guard;
`ifdef IMEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Boot load, done with the last write, then RUN traffic.
        for (int i = 0; i < 5; i++)
            tbl[i] = mk(1, 6'd7, 1, 6'(i), 32'h00F00193 + 32'(i), 0, 1, 1, 1, 7'(i));
        tbl[5]  = mk(1, 6'd7, 1, 6'd5, 32'h00F00198, 1, 1, 1, 1, 7'd5);
        tbl[6]  = mk(1, 6'd3, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6);
        tbl[7]  = mk(0, 6'd0, 1, 6'd10, 32'hDEADBEEF, 1, 1, 0, 0, 7'd6);
        tbl[8]  = mk(1, 6'd10, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6);
        tbl[9]  = mk(0, 6'd0, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6);
        tbl[10] = mk(0, 6'd0, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6);

        idle_inputs();
        core_req = 1'b1;
        rst_n = 1'b0;
        #12;
        check("rst_core_valid", 32'(core_valid), 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_boot_busy", 32'(boot_busy), 32'd1);
        check("rst_core_stall", 32'(core_stall), 32'd1);
        check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("v%0d", i));
        check("hold_core_rdata", core_rdata, 32'hDEADBEEF);

        // Core and loader contend for 8 cycles.
        for (int k = 1; k <= 8; k++) begin
            logic g;
            g = guard && (k % 4 == 0);
            apply(mk(1, 6'd1, 1, 6'd20, 32'hA5A50000 + 32'(k), 0, g, g, 0, 7'd6),
                  $sformatf("starve%0d", k));
        end
        apply(mk(0, 6'd0, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6), "drain");

        // Asynchronous reset while a fetch result is in flight.
        apply(mk(1, 6'd2, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd6), "fetch_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_core_valid", 32'(core_valid), 32'd0);
        check("arst_boot_busy", 32'(boot_busy), 32'd1);
        check("arst_load_count", 32'(load_count), 32'd0);
        check("arst_core_rdata", core_rdata, 32'd0);
        sb_q.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 70 boot writes saturate the counter at 64.
        for (int i = 0; i < 70; i++)
            apply(mk(1, 6'd0, 1, 6'(i % 64), 32'h1000 + 32'(i), 0, 1, 1, 1,
                     (i < 64) ? 7'(i) : 7'd64), $sformatf("sat%0d", i));
        apply(mk(0, 6'd0, 1, 6'd33, 32'h2222, 1, 1, 0, 1, 7'd64), "sat_done");
        apply(mk(0, 6'd0, 1, 6'd34, 32'h3333, 0, 1, 0, 0, 7'd64), "run_wr");
        apply(mk(1, 6'd33, 1, 6'd35, 32'h4444, 0, 0, 0, 0, 7'd64), "run_rd");
        apply(mk(0, 6'd0, 0, 6'd0, 32'h0, 0, 0, 0, 0, 7'd64), "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
